// File: rtl/uart_rx_unit.sv
// uart_rx_unit: standalone UART receive path.
//   16x-oversampled 8N1 receiver (LSB first, idle high), free-running baud
//   tick generator, and a first-word-fall-through RX FIFO popped by the host.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rx        serial line, asynchronous to clk
//   rd_uart   pop request (ignored while rx_empty)
//   r_data    FIFO head byte, right-justified, upper bits 0
//   rx_empty  FIFO empty
//   rx_full   FIFO full
//   frame_err 1-clk pulse when the stop bit is sampled 0
//   overrun   1-clk pulse when a completed byte is dropped on a full FIFO
module uart_rx_unit #(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200,
  parameter int dbit     = 8,
  parameter int fifo_aw  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_uart,
  output logic [7:0] r_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV   = clk_freq / (16 * baud);
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 ** fifo_aw;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [2:0]    N_LAST    = 3'(dbit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- input synchronizer ----------------
  logic rx_meta, rx_s;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------- baud tick (16x) ----------------
  logic [CW-1:0] tick_cnt;
  logic          tick;
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- receive FSM ----------------
  state_t     state;
  logic [3:0] s_reg;
  logic [2:0] n_reg;
  logic [7:0] b_reg;
  logic       push_q;      // completed good frame, written to FIFO next edge
  logic [7:0] push_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          // Tick counter keeps running: up to one tick of start-edge jitter.
          if (!rx_s) begin
            state <= START;
            s_reg <= '0;
          end
        end
        START: if (tick) begin
          if (s_reg == 4'd7) begin
            s_reg <= '0;
            n_reg <= '0;
            // Line back high at mid start bit: a glitch, drop silently.
            state <= rx_s ? IDLE : DATA;
          end else begin
            s_reg <= s_reg + 1'b1;
          end
        end
        DATA: if (tick) begin
          if (s_reg == 4'd15) begin
            s_reg <= '0;
            b_reg <= {rx_s, b_reg[7:1]};
            if (n_reg == N_LAST) state <= STOP;
            else                 n_reg <= n_reg + 1'b1;
          end else begin
            s_reg <= s_reg + 1'b1;
          end
        end
        STOP: if (tick) begin
          if (s_reg == 4'd15) begin
            // Return to IDLE at mid stop bit so a back-to-back start edge
            // half a bit later is still caught.
            state     <= IDLE;
            s_reg     <= '0;
            push_q    <= rx_s;
            frame_err <= ~rx_s;
            // dbit < 8 leaves the data in the upper bits; right-justify.
            push_data <= b_reg >> (8 - dbit);
          end else begin
            s_reg <= s_reg + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [fifo_aw:0]   wptr, rptr;
  logic [7:0]         mem [DEPTH];
  logic               pop, wr_en;

  assign rx_empty = (wptr == rptr);
  assign rx_full  = (wptr[fifo_aw] != rptr[fifo_aw]) &&
                    (wptr[fifo_aw-1:0] == rptr[fifo_aw-1:0]);
  assign pop      = rd_uart && !rx_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en    = push_q && (!rx_full || pop);
  assign r_data   = rx_empty ? 8'h00 : mem[rptr[fifo_aw-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[fifo_aw-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_q && rx_full && !pop;
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: table of single-frame vectors, hand sequences for
// glitch / overrun / reset-mid-frame / back-to-back, then random frames and
// pops checked against a queue model of the receive FIFO.
module tb_uart_rx_unit;

  // Smaller divisor keeps the run short; frame timing rules are unchanged.
  localparam int CLK_FREQ = 16 * 115200 * 10;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / (16 * BAUD);
  localparam int BIT      = 16 * DIV;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_uart = 1'b0;
  logic [7:0] r_data;
  logic       rx_empty, rx_full, frame_err, overrun;

  uart_rx_unit #(.clk_freq(CLK_FREQ), .baud(BAUD), .dbit(8), .fifo_aw(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_uart(rd_uart), .r_data(r_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .frame_err(frame_err), .overrun(overrun)
  );

  always #10 clk = ~clk;

  int tests = 0, fails = 0;
  int fe_cnt = 0, ov_cnt = 0;     // cycles each pulse was seen high
  int exp_fe = 0, exp_ov = 0;
  logic [7:0] q[$];               // model of FIFO contents

  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun)   ov_cnt = ov_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v, input int n);
    rx = v;
    idle(n);
  endtask

  // A bad stop bit is released early so the line is high again by the time
  // a spurious start detection reaches its mid-start check.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_out(1'b0, BIT);
    for (int i = 0; i < 8; i++) bit_out(d[i], BIT);
    if (stop) bit_out(1'b1, BIT);
    else begin
      bit_out(1'b0, 3 * BIT / 4);
      bit_out(1'b1, BIT / 4);
    end
    rx = 1'b1;
  endtask

  // Model: reaction of the receive path to one whole frame.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop)                 exp_fe++;
    else if (q.size() == DEPTH) exp_ov++;
    else                       q.push_back(d);
  endtask

  task automatic pop_one;
    @(posedge clk); #1 rd_uart = 1'b1;
    @(posedge clk); #1 rd_uart = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic check_state(input string tag);
    check({tag, "_empty"}, rx_empty, q.size() == 0);
    check({tag, "_full"},  rx_full,  q.size() == DEPTH);
    if (q.size() > 0) check({tag, "_rdata"}, r_data, q[0]);
    check({tag, "_fe"}, fe_cnt, exp_fe);
    check({tag, "_ov"}, ov_cnt, exp_ov);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_empty;
    logic [7:0] exp_rdata;
    int         exp_fe;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'h00, 1};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 0};
    tbl[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 0};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 0};

    // Reset state
    idle(5);
    check("rst_rdata", r_data, 8'h00);
    check("rst_empty", rx_empty, 1'b1);
    check("rst_full", rx_full, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_ov", overrun, 1'b0);
    rst = 1'b1;
    idle(BIT);

    // Table: one frame, then check and pop
    foreach (tbl[i]) begin
      int fe0;
      fe0 = fe_cnt;
      send_frame(tbl[i].data, tbl[i].stop);
      idle(BIT / 2);
      exp_fe += tbl[i].exp_fe;
      check("tbl_empty", rx_empty, tbl[i].exp_empty);
      check("tbl_fe", fe_cnt - fe0, tbl[i].exp_fe);
      check("tbl_ov", ov_cnt, 0);
      if (!tbl[i].exp_empty) begin
        check("tbl_rdata", r_data, tbl[i].exp_rdata);
        pop_one;
        check("tbl_pop_empty", rx_empty, 1'b1);
      end
    end

    // Short low glitch on an idle line
    bit_out(1'b0, BIT / 4);
    bit_out(1'b1, 2 * BIT);
    check_state("glitch");

    // Fill to full, then overrun on the fifth frame
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      idle(BIT / 2);
      model_frame(8'(i), 1'b1);
      check_state("fill");
      if (i == 4) check("full_after_4", rx_full, 1'b1);
    end
    check("overrun_once", ov_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_rdata", r_data, 8'(i));
      pop_one;
    end
    check_state("drained");

    // Reset in the middle of data bit 3
    bit_out(1'b0, BIT);
    bit_out(1'b0, BIT);
    bit_out(1'b1, BIT);
    bit_out(1'b0, BIT);
    bit_out(1'b1, BIT / 2);
    rst = 1'b0;
    #1;
    check("midrst_empty", rx_empty, 1'b1);
    check("midrst_full", rx_full, 1'b0);
    check("midrst_rdata", r_data, 8'h00);
    rx = 1'b1;
    idle(10);
    check("midrst_fe", frame_err, 1'b0);
    check("midrst_ov", overrun, 1'b0);
    rst = 1'b1;
    q.delete();
    idle(2 * BIT);
    check_state("after_rst");
    send_frame(8'h5A, 1'b1);
    idle(BIT / 2);
    model_frame(8'h5A, 1'b1);
    check_state("post_rst_frame");
    check("post_rst_5a", r_data, 8'h5A);
    pop_one;

    // Back-to-back frames, one stop bit each
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(BIT / 2);
    model_frame(8'h00, 1'b1);
    model_frame(8'hFF, 1'b1);
    model_frame(8'h55, 1'b1);
    check_state("b2b");
    while (q.size() > 0) begin
      pop_one;
      check_state("b2b_pop");
    end

    // Random frames and pops against the model
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic       st;
      int         np;
      np = $urandom_range(0, 2);
      for (int j = 0; j < np; j++) begin
        pop_one;
        check_state("rnd_pop");
      end
      d  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      send_frame(d, st);
      idle(BIT / 2);
      model_frame(d, st);
      check_state("rnd_frame");
    end
    while (q.size() > 0) begin
      pop_one;
      check_state("rnd_drain");
    end
    pop_one;
    check_state("pop_when_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
